// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        S_DEAD = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } slot_state_t;

    // Active-low anode vector with only bit idx driven low; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int unsigned idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/display_slot_timer.sv
// Digit slot prescaler: free-running slot counter with a one-cycle end-of-slot strobe.
module display_slot_timer #(
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             slot_end
);

    assign slot_end = (slot_cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// N-digit 7-segment scan controller: dead-time, PWM brightness, leading-zero blanking
// and frame-synchronous value loading.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 16,
    parameter int BRIGHT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NIBBLE_W*N_DIGITS-1:0]  load_value,
    input  logic                          blank_lz,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [N_DIGITS-1:0]           anodes,
    output logic [NIBBLE_W-1:0]           digit_hex,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int VAL_W = NIBBLE_W * N_DIGITS;
    localparam int STEP  = (PRESCALE - DEAD_CYCLES) / (2**BRIGHT_W - 1);

    logic [CNT_W-1:0]    slot_cnt;
    logic                slot_end;
    slot_state_t         state, state_next;
    logic [VAL_W-1:0]    active, shadow, active_next;
    logic                pending, pending_next;
    logic [CNT_W-1:0]    on_time_r, on_time_now;
    logic                lit_r, lit_now;
    logic [VAL_W-1:0]    upper;
    logic [IDX_W-1:0]    digit_next;
    logic [N_DIGITS-1:0] anodes_next;
    logic                accept, boundary;

    display_slot_timer #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .slot_cnt (slot_cnt),
        .slot_end (slot_end)
    );

    // Brightness and blanking are evaluated in slot cycle 0 and held for the rest of the slot.
    always_comb begin
        upper       = active >> (NIBBLE_W * int'(digit_idx));
        on_time_now = (slot_cnt == '0) ? CNT_W'(32'(brightness) * STEP) : on_time_r;
        lit_now     = (slot_cnt == '0) ? !(blank_lz && digit_idx != '0 && upper == '0) : lit_r;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_DEAD:  if (slot_cnt == CNT_W'(DEAD_CYCLES - 1))
                         state_next = (on_time_now != '0) ? S_ON : S_OFF;
            S_ON:    if ((slot_cnt - CNT_W'(DEAD_CYCLES - 1)) == on_time_now)
                         state_next = S_OFF;
            S_OFF:   state_next = S_OFF;
            default: state_next = S_DEAD;
        endcase
        if (slot_end)
            state_next = S_DEAD;
    end

    always_comb begin
        boundary     = slot_end && (digit_idx == IDX_W'(N_DIGITS - 1));
        accept       = load_valid && load_ready;
        digit_next   = digit_idx;
        if (slot_end)
            digit_next = (digit_idx == IDX_W'(N_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        active_next  = (boundary && pending) ? shadow : active;
        pending_next = pending;
        if (accept)
            pending_next = 1'b1;
        else if (boundary)
            pending_next = 1'b0;
        anodes_next  = '1;
        if (state_next == S_ON && lit_now)
            anodes_next = N_DIGITS'(onehot_n(32'(digit_idx)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_DEAD;
            digit_idx   <= '0;
            anodes      <= '1;
            digit_hex   <= '0;
            frame_start <= 1'b0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            load_ready  <= 1'b0;
            on_time_r   <= '0;
            lit_r       <= 1'b1;
        end else begin
            state       <= state_next;
            digit_idx   <= digit_next;
            anodes      <= anodes_next;
            digit_hex   <= active_next[NIBBLE_W*int'(digit_next) +: NIBBLE_W];
            frame_start <= boundary;
            active      <= active_next;
            pending     <= pending_next;
            load_ready  <= !pending_next;
            on_time_r   <= on_time_now;
            lit_r       <= lit_now;
            if (accept)
                shadow <= load_value;
        end
    end

endmodule
